// File: rtl/pci_target_if.sv
// Shared PCI-style bus between one initiator and the pci_target responder.
// Each side drives AD, tready and devsel only through its own output enable.
// The tri-state resolution lives here, so each enable can be inspected directly.
interface pci_target_if;
  // Initiator-owned control.
  logic        iframe;
  logic [3:0]  CBE;
  logic        iready;

  // Initiator drive of AD: address phase and write data.
  logic        ini_ad_oe;
  logic [31:0] ini_ad;

  // Target drive of AD (read data), tready and devsel.
  logic        tgt_ad_oe;
  logic [31:0] tgt_ad;
  logic        tgt_tready_oe;
  logic        tgt_tready;
  logic        tgt_devsel_oe;
  logic        tgt_devsel;

  // Resolved bus lines.
  wire  [31:0] AD;
  wire         tready;
  wire         devsel;

  assign AD     = tgt_ad_oe     ? tgt_ad     : 'z;
  assign AD     = ini_ad_oe     ? ini_ad     : 'z;
  assign tready = tgt_tready_oe ? tgt_tready : 1'bz;
  assign devsel = tgt_devsel_oe ? tgt_devsel : 1'bz;

  modport slave (
    input  iframe, CBE, iready, AD, tready, devsel,
    output tgt_ad_oe, tgt_ad, tgt_tready_oe, tgt_tready, tgt_devsel_oe, tgt_devsel
  );

  modport master (
    output iframe, CBE, iready, ini_ad_oe, ini_ad,
    input  AD, tready, devsel,
    input  tgt_ad_oe, tgt_tready_oe, tgt_devsel_oe
  );
endinterface

// File: rtl/pci_target.sv
// PCI-style target with a word memory.
// It claims on an address match with medium decode (devsel one clock after
// the address phase). It accepts zero-wait burst writes with byte enables, and
// returns burst reads after one turnaround cycle. A backdoor port reads
// memory combinationally.
module pci_target #(
  parameter logic [31:0] DEV_BASE = 32'h0000_0100,
  parameter int          AW       = 4,
  parameter logic [3:0]  CMD_WR   = 4'b1000,
  parameter logic [3:0]  CMD_RD   = 4'b0000
) (
  input  logic          clk,
  input  logic          rst,
  pci_target_if.slave   bus,
  output logic          busy,
  output logic [7:0]    xfer_count,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    RD_TURN,
    RD_DATA,
    RELEASE
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] idx;
  logic [31:0]   mem [DEPTH];

  logic claim_wr, claim_rd, data_state, xfer, last_xfer, abort;

  // Address decode and data-phase qualifiers.
  always_comb begin
    claim_wr   = (state == IDLE) && !bus.iframe &&
                 (bus.AD[31:8] == DEV_BASE[31:8]) && (bus.CBE == CMD_WR);
    claim_rd   = (state == IDLE) && !bus.iframe &&
                 (bus.AD[31:8] == DEV_BASE[31:8]) && (bus.CBE == CMD_RD);
    data_state = (state == WR_DATA) || (state == RD_DATA);
    // tready is driven low in both data states, so iready alone qualifies a transfer.
    xfer       = data_state && !bus.iready;
    last_xfer  = xfer && bus.iframe;
    abort      = data_state && bus.iframe && bus.iready;
  end

  // Next-state selection and tri-state drive for each state.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nxt         = state;
    bus.tgt_ad_oe     = 1'b0;
    bus.tgt_ad        = '0;
    bus.tgt_tready_oe = 1'b0;
    bus.tgt_tready    = 1'b1;
    bus.tgt_devsel_oe = 1'b0;
    bus.tgt_devsel    = 1'b1;

    case (state)
      IDLE: begin
        if (claim_wr)      state_nxt = WR_DATA;
        else if (claim_rd) state_nxt = RD_TURN;
      end
      WR_DATA: begin
        bus.tgt_devsel_oe = 1'b1;
        bus.tgt_devsel    = 1'b0;
        bus.tgt_tready_oe = 1'b1;
        bus.tgt_tready    = 1'b0;
        if (last_xfer || abort) state_nxt = RELEASE;
      end
      RD_TURN: begin
        bus.tgt_devsel_oe = 1'b1;
        bus.tgt_devsel    = 1'b0;
        bus.tgt_tready_oe = 1'b1;
        bus.tgt_tready    = 1'b1;
        state_nxt         = RD_DATA;
      end
      RD_DATA: begin
        bus.tgt_devsel_oe = 1'b1;
        bus.tgt_devsel    = 1'b0;
        bus.tgt_tready_oe = 1'b1;
        bus.tgt_tready    = 1'b0;
        bus.tgt_ad_oe     = 1'b1;
        bus.tgt_ad        = mem[idx];
        if (last_xfer || abort) state_nxt = RELEASE;
      end
      RELEASE: begin
        // Drive both lines high for one cycle before letting them float.
        bus.tgt_devsel_oe = 1'b1;
        bus.tgt_devsel    = 1'b1;
        bus.tgt_tready_oe = 1'b1;
        bus.tgt_tready    = 1'b1;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, word index and transfer counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      xfer_count <= '0;
    end else begin
      state <= state_nxt;
      if (claim_wr || claim_rd) begin
        idx        <= bus.AD[AW+1:2];
        xfer_count <= '0;
      end else if (xfer) begin
        idx <= idx + AW'(1);
        if (xfer_count != 8'hFF) xfer_count <= xfer_count + 8'd1;
      end
    end
  end

  // Word memory: byte-enabled writes on write transfers, cleared by reset.
  always_ff @(posedge clk) begin
    // NOTE: this memory is reset explicitly because the bench expects all words zero after reset; that rules out a RAM macro.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (xfer && (state == WR_DATA)) begin
      for (int b = 0; b < 4; b++) begin
        if (!bus.CBE[b]) mem[idx][8*b +: 8] <= bus.AD[8*b +: 8];
      end
    end
  end

  assign busy     = (state != IDLE);
  assign dbg_data = mem[dbg_addr];

endmodule

// File: doc/pci_target.md
Name: pci_target

Overview:
Dedicated PCI-style target (responder). It answers the initiator transactions that `device` and the arbiter place on the shared bus. It decodes the address phase, claims the bus with devsel, and accepts burst writes into an internal word memory, or returns burst reads from it. It uses the same active-low iframe/iready/tready/devsel handshake and the same command encoding as the rest of the design. A backdoor port exposes memory contents to the bench.

Parameters:
DEV_BASE, 32'h0000_0100, base address; the target claims when AD[31:8]==DEV_BASE[31:8]
AW, 4, word-index width; memory depth is 2**AW words
CMD_WR, 4'b1000, CBE value in the address phase meaning write
CMD_RD, 4'b0000, CBE value in the address phase meaning read

Ports:
clk  in  1  single clock; all state changes on its rising edge
rst  in  1  synchronous, active-high reset
iframe  in  1  active low; asserted by the initiator for the whole transaction, deasserted with the last data phase
AD  inout  32  address in the address phase, data in data phases; driven by this block only during read data phases
CBE  in  4  command in the address phase; active-low byte enables in data phases
iready  in  1  active low; initiator ready
tready  inout  32'bz-style tri-state, 1 bit  active low; target ready; driven only while this block owns the transaction
devsel  inout  1  active low; device selected; tri-state like tready
busy  out  1  high from the claim cycle until the release cycle inclusive
xfer_count  out  8  number of data transfers completed in the current or last transaction
dbg_addr  in  AW  backdoor word index
dbg_data  out  32  combinational read of mem[dbg_addr]

Behaviour:
- Reset:
  - state=IDLE; tready, devsel and AD output enables off (all Z).
  - busy=0, xfer_count=0, all memory words=0.
  - A reset asserted mid-transaction releases the bus on the next edge. No partial write after that edge.
- States: IDLE, WR_DATA, RD_TURN, RD_DATA, RELEASE.
- IDLE (address decode):
  - Condition: rising edge with iframe==0, AD[31:8] matching, and CBE equal to CMD_WR or CMD_RD.
  - Action: latch idx=AD[AW+1:2] and the command; clear xfer_count; set busy=1.
  - Next state: WR_DATA (write) or RD_TURN (read).
  - Any other CBE value, or an address mismatch: stay in IDLE and drive nothing.
- Claim latency: devsel is driven 0 starting the cycle after the address phase (medium decode, 1 clock), in both WR_DATA and RD_TURN.
- WR_DATA:
  - tready is driven 0 immediately (zero wait states).
  - Data transfer = rising edge with iready==0 and tready==0.
  - On each transfer, for each byte i with CBE[i]==0, write mem[idx][8i+7:8i] <= AD[8i+7:8i]. Then idx<=idx+1 and xfer_count<=xfer_count+1.
  - iready==1 is an initiator wait state: hold, no write.
- RD_TURN:
  - Turnaround cycle: devsel=0, tready driven 1, AD not driven.
  - Next edge: go to RD_DATA with AD driving mem[idx] and tready=0.
- RD_DATA:
  - On each transfer edge, idx<=idx+1 and xfer_count++. AD presents mem[new idx] the following cycle.
  - While iready==1, AD and idx hold.
- Burst end:
  - A transfer edge with iframe==1 is the last data phase.
  - On that edge, go to RELEASE: tready=1, devsel=1 driven for one cycle, AD released.
  - Then IDLE with all signals Z and busy=0.
- Initiator abort: iframe==1 and iready==1 while in a data state → RELEASE without a transfer.
- Wrap-around: idx increments modulo 2**AW (index 2**AW-1 → 0). xfer_count saturates at 255.
- Write collision: a transfer to the same index as dbg_addr updates dbg_data in the same cycle it becomes visible, i.e. after the edge.
- Tri-state discipline: tready and devsel are never driven outside claim..RELEASE. AD is never driven outside RD_DATA.

Test Plan:
1. Single write:
   - Stimulus: address phase AD=32'h0000_0104, CBE=1000. Next cycle iready=0, AD=32'hDEAD_BEEF, CBE=0000, iframe=1.
   - Required: devsel and tready low the cycle after the address phase; mem[1]=DEADBEEF; xfer_count=1; RELEASE for 1 cycle, then Z.
2. Byte-enable write:
   - Stimulus: write AD=32'h1122_3344 to index 2 with data-phase CBE=4'b1010.
   - Required: dbg_data at index 2 = 32'h0022_0044 (from reset).
3. Read burst with wait state:
   - Setup: preload mem[14]=A, mem[15]=B, mem[0]=C.
   - Stimulus: read at AD=32'h0000_0138; 3 data phases, iready=1 on the 2nd.
   - Required: one turnaround cycle with AD=Z; AD returns A, B, C in sequence (wrap 15→0); B is held across the wait state; xfer_count=3.
4. Address miss: AD=32'h0000_0200, CBE=1000 → devsel, tready and AD stay Z; busy=0; no memory change.
5. Abort: after the claim, iframe=1 and iready=1 → RELEASE next cycle; no write; xfer_count=0.
6. Reset mid-burst: rst=1 during a read data phase → the next edge has all tri-states at Z, state IDLE, memory zeroed.
